matmul_stream_arbiter: RTL and testbench

- Shares the matrix multiplier's single AXI-Stream input (input_r_*_0) between two packet sources, in0 and in1.
- Each packet is a header word (TDATA[31:24]=8'hFF, e.g. 32'hFF000240 or 32'hFF000120) followed by data words, and ends on a TLAST beat.
- Arbitration is round-robin at packet granularity. A startup warm-up hold-off gates all traffic. Packets are never interleaved.
- Adds a registered output slice, per-input packet counters and sticky format-error flags.

---
 rtl/matmul_arb_pkg.sv | 31 +++
 rtl/axis_skid_slice.sv | 52 +++++
 rtl/matmul_stream_arbiter.sv | 134 +++++++++++++
 tb/tb_matmul_stream_arbiter.sv | 353 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/matmul_arb_pkg.sv
// Shared definitions for the matmul input-stream arbiter.
//   state_t  : arbiter FSM encoding
//   beat_t   : {TDATA, TLAST} payload carried through the output slice
//   HDR_*    : packet header tag/field and the two standard header words
//   is_hdr() : true when a word carries the header tag
package matmul_arb_pkg;

    typedef enum logic [1:0] {
        WARMUP = 2'd0,
        IDLE   = 2'd1,
        XFER   = 2'd2
    } state_t;

    localparam logic [7:0]  HDR_TAG = 8'hFF;
    localparam int          HDR_MSB = 31;
    localparam int          HDR_LSB = 24;
    localparam logic [31:0] HDR_A   = 32'hFF000240;
    localparam logic [31:0] HDR_B   = 32'hFF000120;

    typedef struct packed {
        logic [31:0] tdata;
        logic        tlast;
    } beat_t;

    localparam int BEAT_W = $bits(beat_t);

    function automatic logic is_hdr(input logic [31:0] d);
        return d[HDR_MSB:HDR_LSB] == HDR_TAG;
    endfunction

endpackage

// File: rtl/axis_skid_slice.sv
// Two-entry registered AXI-Stream slice (generic payload width).
//   clk, reset        : clock, async active-high reset
//   s_data/s_valid    : upstream beat in
//   s_ready           : registered; high while fewer than 2 entries held
//   m_data/m_valid    : downstream beat out, driven straight from storage
//   m_ready           : downstream ready
// Head entry never changes while m_valid & !m_ready, so the output is
// stable during stalls. Full throughput when m_ready stays high.
module axis_skid_slice #(
    parameter int W = 33
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] s_data,
    input  logic         s_valid,
    output logic         s_ready,
    output logic [W-1:0] m_data,
    output logic         m_valid,
    input  logic         m_ready
);

    logic [1:0][W-1:0] mem;
    logic              rd_ptr, wr_ptr;
    logic [1:0]        count, count_nxt;
    logic              push, pop;

    assign push      = s_valid & s_ready;
    assign pop       = m_valid & m_ready;
    assign count_nxt = count + 2'(push) - 2'(pop);
    assign m_valid   = (count != 2'd0);
    assign m_data    = mem[rd_ptr];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem     <= '0;
            rd_ptr  <= 1'b0;
            wr_ptr  <= 1'b0;
            count   <= 2'd0;
            s_ready <= 1'b1;
        end else begin
            if (push) begin
                mem[wr_ptr] <= s_data;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop)
                rd_ptr <= ~rd_ptr;
            count   <= count_nxt;
            s_ready <= (count_nxt < 2'd2);
        end
    end

endmodule

// File: rtl/matmul_stream_arbiter.sv
// Packet-granular round-robin arbiter feeding the matrix multiplier's
// single AXI-Stream input from two sources.
//   clk, reset                 : clock, async active-high reset
//   in0_* / in1_*              : source streams (TDATA/TVALID/TLAST/TREADY)
//   input_r_*_0                : registered stream to the multiplier
//   warmup_done                : sticky, set once the start-up hold-off ends
//   grant_idx                  : source currently or last granted
//   busy                       : high while a packet is being transferred
//   pkt_cnt0/pkt_cnt1          : completed packets per source (wrapping)
//   hdr_err/len_err            : sticky per-source format error flags
module matmul_stream_arbiter
    import matmul_arb_pkg::*;
#(
    parameter logic [19:0] WARMUP_CYCLES = 20'd20000,
    parameter logic [9:0]  MAX_BEATS     = 10'd1023
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] in0_TDATA,
    input  logic        in0_TVALID,
    input  logic        in0_TLAST,
    output logic        in0_TREADY,
    input  logic [31:0] in1_TDATA,
    input  logic        in1_TVALID,
    input  logic        in1_TLAST,
    output logic        in1_TREADY,
    output logic [31:0] input_r_TDATA_0,
    output logic        input_r_TVALID_0,
    output logic        input_r_TLAST_0,
    input  logic        input_r_TREADY_0,
    output logic        warmup_done,
    output logic        grant_idx,
    output logic        busy,
    output logic [15:0] pkt_cnt0,
    output logic [15:0] pkt_cnt1,
    output logic [1:0]  hdr_err,
    output logic [1:0]  len_err
);

    state_t      state;
    logic        rdy_q;
    logic [19:0] wu_cnt, wu_nxt;
    logic        last_grant;
    logic [10:0] beat_cnt, beat_nxt;   // one bit wider than MAX_BEATS to see overflow

    logic        xfer, pick, accept, s_ready;
    logic [31:0] g_data;
    logic        g_valid, g_last;
    beat_t       s_beat, m_beat;

    assign xfer     = (state == XFER);
    assign g_valid  = grant_idx ? in1_TVALID : in0_TVALID;
    assign g_data   = grant_idx ? in1_TDATA  : in0_TDATA;
    assign g_last   = grant_idx ? in1_TLAST  : in0_TLAST;
    assign accept   = xfer & g_valid & s_ready;

    assign in0_TREADY = xfer & ~grant_idx & s_ready;
    assign in1_TREADY = xfer &  grant_idx & s_ready;

    // Tie goes to the source that did not win last time.
    assign pick     = (in0_TVALID & in1_TVALID) ? ~last_grant : in1_TVALID;
    assign wu_nxt   = (rdy_q && wu_cnt != 20'hFFFFF) ? wu_cnt + 20'd1 : wu_cnt;
    assign beat_nxt = (beat_cnt != 11'h7FF) ? beat_cnt + 11'd1 : beat_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= WARMUP;
            rdy_q       <= 1'b0;
            wu_cnt      <= '0;
            last_grant  <= 1'b1;
            beat_cnt    <= '0;
            warmup_done <= 1'b0;
            grant_idx   <= 1'b0;
            busy        <= 1'b0;
            pkt_cnt0    <= '0;
            pkt_cnt1    <= '0;
            hdr_err     <= '0;
            len_err     <= '0;
        end else begin
            rdy_q <= input_r_TREADY_0;
            case (state)
                WARMUP: begin
                    wu_cnt <= wu_nxt;
                    if (wu_nxt == WARMUP_CYCLES) begin
                        state       <= IDLE;
                        warmup_done <= 1'b1;
                    end
                end
                IDLE: begin
                    if (in0_TVALID | in1_TVALID) begin
                        grant_idx <= pick;
                        beat_cnt  <= '0;
                        busy      <= 1'b1;
                        state     <= XFER;
                    end
                end
                XFER: begin
                    if (accept) begin
                        beat_cnt <= beat_nxt;
                        if (beat_cnt == 11'd0 && !is_hdr(g_data))
                            hdr_err[grant_idx] <= 1'b1;
                        if (beat_nxt > {1'b0, MAX_BEATS})
                            len_err[grant_idx] <= 1'b1;
                        if (g_last) begin
                            if (grant_idx) pkt_cnt1 <= pkt_cnt1 + 16'd1;
                            else           pkt_cnt0 <= pkt_cnt0 + 16'd1;
                            last_grant <= grant_idx;
                            busy       <= 1'b0;
                            state      <= IDLE;
                        end
                    end
                end
                default: state <= WARMUP;
            endcase
        end
    end

    assign s_beat = '{tdata: g_data, tlast: g_last};

    axis_skid_slice #(.W(BEAT_W)) u_slice (
        .clk     (clk),
        .reset   (reset),
        .s_data  (s_beat),
        .s_valid (accept),
        .s_ready (s_ready),
        .m_data  (m_beat),
        .m_valid (input_r_TVALID_0),
        .m_ready (input_r_TREADY_0)
    );

    assign input_r_TDATA_0 = m_beat.tdata;
    assign input_r_TLAST_0 = m_beat.tlast;

endmodule

// File: tb/tb_matmul_stream_arbiter.sv
module tb_matmul_stream_arbiter;
    import matmul_arb_pkg::*;

    logic        clk, reset;
    logic [31:0] in0_TDATA, in1_TDATA;
    logic        in0_TVALID, in0_TLAST, in0_TREADY;
    logic        in1_TVALID, in1_TLAST, in1_TREADY;
    logic [31:0] input_r_TDATA_0;
    logic        input_r_TVALID_0, input_r_TLAST_0, input_r_TREADY_0;
    logic        warmup_done, grant_idx, busy;
    logic [15:0] pkt_cnt0, pkt_cnt1;
    logic [1:0]  hdr_err, len_err;

    int n_cmp = 0;
    int n_fail = 0;
    int timeouts = 0;
    int stab_err = 0;
    bit abort = 0;
    bit rand_mode = 0;
    logic [32:0] outq[$];
    logic [32:0] expq[$];
    bit        stall_q = 0;
    logic [32:0] hold_q = '0;

    matmul_stream_arbiter #(.WARMUP_CYCLES(20'd16), .MAX_BEATS(10'd8)) dut (
        .clk(clk), .reset(reset),
        .in0_TDATA(in0_TDATA), .in0_TVALID(in0_TVALID), .in0_TLAST(in0_TLAST), .in0_TREADY(in0_TREADY),
        .in1_TDATA(in1_TDATA), .in1_TVALID(in1_TVALID), .in1_TLAST(in1_TLAST), .in1_TREADY(in1_TREADY),
        .input_r_TDATA_0(input_r_TDATA_0), .input_r_TVALID_0(input_r_TVALID_0),
        .input_r_TLAST_0(input_r_TLAST_0), .input_r_TREADY_0(input_r_TREADY_0),
        .warmup_done(warmup_done), .grant_idx(grant_idx), .busy(busy),
        .pkt_cnt0(pkt_cnt0), .pkt_cnt1(pkt_cnt1), .hdr_err(hdr_err), .len_err(len_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Downstream ready: changes 2 ns after each rising edge.
    initial begin
        input_r_TREADY_0 = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            input_r_TREADY_0 = rand_mode ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Output monitor: records accepted beats, counts stall instability.
    always @(negedge clk) begin
        if (reset) begin
            stall_q = 1'b0;
        end else begin
            if (stall_q && (!input_r_TVALID_0 || {input_r_TLAST_0, input_r_TDATA_0} !== hold_q))
                stab_err++;
            if (input_r_TVALID_0 && input_r_TREADY_0)
                outq.push_back({input_r_TLAST_0, input_r_TDATA_0});
            stall_q = input_r_TVALID_0 && !input_r_TREADY_0;
            hold_q  = {input_r_TLAST_0, input_r_TDATA_0};
        end
    end

    initial begin
        #600000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

    function automatic logic [74:0] outs_vec();
        return {input_r_TVALID_0, input_r_TLAST_0, input_r_TDATA_0, warmup_done, grant_idx, busy,
                pkt_cnt0, pkt_cnt1, hdr_err, len_err, in0_TREADY, in1_TREADY};
    endfunction

    task automatic drive(input int src, input logic v, input logic [31:0] d, input logic l);
        if (src == 0) begin in0_TVALID = v; in0_TDATA = d; in0_TLAST = l; end
        else          begin in1_TVALID = v; in1_TDATA = d; in1_TLAST = l; end
    endtask

    // Sends first word then n_words copies of word; TLAST on the final beat.
    task automatic send_pkt(input int src, input logic [31:0] first, input int n_words,
                            input logic [31:0] word);
        logic r;
        bit bail;
        bail = 0;
        r = 0;
        for (int i = 0; i <= n_words && !bail; i++) begin
            @(negedge clk);
            drive(src, 1'b1, (i == 0) ? first : word, i == n_words);
            for (int g = 0; g < 2000; g++) begin
                r = (src == 0) ? in0_TREADY : in1_TREADY;
                @(posedge clk);
                if (r || abort) break;
                @(negedge clk);
            end
            if (!r) begin
                bail = 1;
                if (!abort) timeouts++;
            end
        end
        @(negedge clk);
        drive(src, 1'b0, 32'h0, 1'b0);
    endtask

    task automatic add_pkt(input logic [31:0] first, input int n_words, input logic [31:0] word);
        expq.push_back({n_words == 0, first});
        for (int i = 1; i <= n_words; i++) expq.push_back({i == n_words, word});
    endtask

    task automatic wait_out(input int n);
        for (int c = 0; c < 3000 && outq.size() < n; c++) @(negedge clk);
        if (outq.size() < n) timeouts++;
        repeat (4) @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        abort = 1;
        drive(0, 1'b0, 32'h0, 1'b0);
        drive(1, 1'b0, 32'h0, 1'b0);
        repeat (3) @(negedge clk);
        abort = 0;
        reset = 1'b0;
        for (int c = 0; c < 100 && !warmup_done; c++) @(negedge clk);
        if (!warmup_done) timeouts++;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        n_cmp++;
        if (outs_vec() !== 75'd0) begin
            n_fail++;
            $display("FAIL reset_state: got %h want 0", outs_vec());
        end
    endtask

    task automatic test_warmup();
        int viol, mism, ob;
        bit found;
        ob = outq.size();
        @(negedge clk);
        reset = 1'b0;
        fork
            send_pkt(0, HDR_A, 2, 32'h1);
            begin
                viol = 0;
                for (int k = 1; k <= 16; k++) begin
                    @(negedge clk);
                    if (in0_TREADY || input_r_TVALID_0 || warmup_done) viol++;
                end
                n_cmp++;
                if (viol != 0) begin n_fail++; $display("FAIL warmup_hold: got %0d violations want 0", viol); end
                @(negedge clk);
                n_cmp++;
                if (warmup_done !== 1'b1) begin n_fail++; $display("FAIL warmup_done_edge17: got %b want 1", warmup_done); end
                found = 0;
                for (int j = 0; j < 3 && !found; j++) begin
                    @(negedge clk);
                    if (input_r_TVALID_0) begin
                        found = 1;
                        n_cmp++;
                        if (input_r_TDATA_0 !== HDR_A) begin
                            n_fail++; $display("FAIL warmup_first_beat: got %h want %h", input_r_TDATA_0, HDR_A);
                        end
                    end
                end
                n_cmp++;
                if (!found) begin n_fail++; $display("FAIL warmup_first_valid: got none want beat within 3 cycles"); end
            end
        join
        wait_out(ob + 3);
        expq.delete();
        add_pkt(HDR_A, 2, 32'h1);
        mism = 0;
        for (int i = 0; i < expq.size(); i++)
            if (ob + i >= outq.size() || outq[ob + i] !== expq[i]) mism++;
        n_cmp++;
        if (mism != 0 || outq.size() - ob != 3) begin
            n_fail++; $display("FAIL warmup_packet: got %0d beats %0d bad want 3 beats 0 bad", outq.size() - ob, mism);
        end
    endtask

    task automatic test_contention(input bit bp);
        int mism, ob;
        do_reset();
        ob = outq.size();
        rand_mode = bp;
        fork
            send_pkt(0, HDR_A, 144, 32'h1);
            send_pkt(1, HDR_B, 72, 32'h1);
        join
        wait_out(ob + 218);
        rand_mode = 0;
        expq.delete();
        add_pkt(HDR_A, 144, 32'h1);
        add_pkt(HDR_B, 72, 32'h1);
        n_cmp++;
        if (outq.size() - ob != 218) begin
            n_fail++; $display("FAIL contention_beats(bp=%0d): got %0d want 218", bp, outq.size() - ob);
        end
        mism = 0;
        for (int i = 0; i < expq.size(); i++)
            if (ob + i >= outq.size() || outq[ob + i] !== expq[i]) mism++;
        n_cmp++;
        if (mism != 0) begin n_fail++; $display("FAIL contention_order(bp=%0d): got %0d bad beats want 0", bp, mism); end
        n_cmp++;
        if (pkt_cnt0 !== 16'd1 || pkt_cnt1 !== 16'd1) begin
            n_fail++; $display("FAIL contention_pkt_cnt(bp=%0d): got %0d/%0d want 1/1", bp, pkt_cnt0, pkt_cnt1);
        end
        n_cmp++;
        if (len_err !== 2'b11 || hdr_err !== 2'b00) begin
            n_fail++; $display("FAIL contention_flags(bp=%0d): got len %b hdr %b want 11 00", bp, len_err, hdr_err);
        end
        n_cmp++;
        if (stab_err != 0) begin n_fail++; $display("FAIL stall_stability(bp=%0d): got %0d want 0", bp, stab_err); end
        n_cmp++;
        if (timeouts != 0) begin n_fail++; $display("FAIL contention_timeout(bp=%0d): got %0d want 0", bp, timeouts); end
    endtask

    task automatic test_hdr_err();
        int mism, ob;
        ob = outq.size();
        send_pkt(1, 32'h00000001, 3, 32'h5);
        wait_out(ob + 4);
        expq.delete();
        add_pkt(32'h00000001, 3, 32'h5);
        mism = 0;
        for (int i = 0; i < expq.size(); i++)
            if (ob + i >= outq.size() || outq[ob + i] !== expq[i]) mism++;
        n_cmp++;
        if (mism != 0) begin n_fail++; $display("FAIL hdr_err_forward: got %0d bad beats want 0", mism); end
        n_cmp++;
        if (hdr_err !== 2'b10) begin n_fail++; $display("FAIL hdr_err_set: got %b want 10", hdr_err); end
        n_cmp++;
        if (pkt_cnt1 !== 16'd2) begin n_fail++; $display("FAIL hdr_err_pkt_cnt1: got %0d want 2", pkt_cnt1); end
        send_pkt(0, HDR_A, 2, 32'h7);
        wait_out(ob + 7);
        n_cmp++;
        if (hdr_err !== 2'b10 || pkt_cnt0 !== 16'd2) begin
            n_fail++; $display("FAIL hdr_err_sticky: got %b cnt0 %0d want 10 cnt0 2", hdr_err, pkt_cnt0);
        end
    endtask

    task automatic test_len_err();
        int viol, acc, mism, ob;
        do_reset();
        ob = outq.size();
        fork
            send_pkt(0, HDR_A, 9, 32'h3);
            begin
                viol = 0;
                acc = 0;
                for (int c = 0; c < 400 && acc < 10; c++) begin
                    @(negedge clk);
                    #1;
                    if (len_err[0] !== (acc >= 9)) viol++;
                    if (in0_TVALID && in0_TREADY) acc++;
                end
                @(negedge clk);
                #1;
                if (len_err[0] !== 1'b1) viol++;
            end
        join
        wait_out(ob + 10);
        n_cmp++;
        if (viol != 0 || acc != 10) begin
            n_fail++; $display("FAIL len_err_timing: got %0d violations %0d beats want 0 and 10", viol, acc);
        end
        n_cmp++;
        if (len_err !== 2'b01) begin n_fail++; $display("FAIL len_err_value: got %b want 01", len_err); end
        expq.delete();
        add_pkt(HDR_A, 9, 32'h3);
        mism = 0;
        for (int i = 0; i < expq.size(); i++)
            if (ob + i >= outq.size() || outq[ob + i] !== expq[i]) mism++;
        n_cmp++;
        if (mism != 0 || outq.size() - ob != 10) begin
            n_fail++; $display("FAIL len_err_forward: got %0d beats %0d bad want 10 beats 0 bad", outq.size() - ob, mism);
        end
        n_cmp++;
        if (pkt_cnt0 !== 16'd1) begin n_fail++; $display("FAIL len_err_pkt_cnt0: got %0d want 1", pkt_cnt0); end
    endtask

    task automatic test_reset_mid();
        int acc, viol, mism, ob;
        fork
            send_pkt(0, HDR_A, 99, 32'h9);
            begin
                acc = 0;
                for (int c = 0; c < 2000 && acc < 50; c++) begin
                    @(negedge clk);
                    #1;
                    if (in0_TVALID && in0_TREADY) acc++;
                end
                @(posedge clk);
                #3;
                reset = 1'b1;
                abort = 1;
                #1;
                n_cmp++;
                if (outs_vec() !== 75'd0) begin
                    n_fail++; $display("FAIL reset_mid_outputs: got %h want 0", outs_vec());
                end
            end
        join
        repeat (2) @(negedge clk);
        abort = 0;
        reset = 1'b0;
        viol = 0;
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            if (warmup_done || busy || pkt_cnt0 != 16'd0) viol++;
        end
        @(negedge clk);
        if (warmup_done !== 1'b1) viol++;
        n_cmp++;
        if (viol != 0) begin n_fail++; $display("FAIL reset_mid_warmup: got %0d violations want 0", viol); end
        ob = outq.size();
        send_pkt(0, HDR_A, 5, 32'h2);
        wait_out(ob + 6);
        expq.delete();
        add_pkt(HDR_A, 5, 32'h2);
        mism = 0;
        for (int i = 0; i < expq.size(); i++)
            if (ob + i >= outq.size() || outq[ob + i] !== expq[i]) mism++;
        n_cmp++;
        if (mism != 0 || outq.size() - ob != 6) begin
            n_fail++; $display("FAIL reset_mid_packet: got %0d beats %0d bad want 6 beats 0 bad", outq.size() - ob, mism);
        end
        n_cmp++;
        if (hdr_err !== 2'b00 || len_err !== 2'b00 || pkt_cnt0 !== 16'd1) begin
            n_fail++; $display("FAIL reset_mid_flags: got hdr %b len %b cnt0 %0d want 00 00 1", hdr_err, len_err, pkt_cnt0);
        end
        n_cmp++;
        if (timeouts != 0) begin n_fail++; $display("FAIL timeouts: got %0d want 0", timeouts); end
    endtask

    initial begin
        reset = 1'b1;
        in0_TVALID = 1'b1; in0_TDATA = HDR_A; in0_TLAST = 1'b0;
        in1_TVALID = 1'b0; in1_TDATA = 32'h0; in1_TLAST = 1'b0;
        test_reset();
        test_warmup();
        test_contention(1'b0);
        test_contention(1'b1);
        test_hdr_err();
        test_len_err();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
